// File: rtl/seq_mult_16bit.sv
`default_nettype none
// ============================================================================
//  Module      : seq_mult_16bit
//  Description : Iterative shift-add 16x16 multiplier controller. Drives an
//                external 16-bit ripple adder (add_x/add_y/add_cin) and
//                consumes its result (add_s/add_cout/add_ov) once per cycle.
//                Produces a 32-bit product {A,Q} 17 cycles after an accepted
//                start.
//                Optional macro SIGNED_MULT_EN selects radix-2 Booth
//                (two's-complement operands); undefined = unsigned only.
//  Revision    : 1.0  initial release
// ============================================================================
module seq_mult_16bit #(
   parameter int WIDTH = 16,
   parameter int CNT_W = 5
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic [WIDTH-1:0]     a_in,
   input  logic [WIDTH-1:0]     b_in,
   output logic                 busy,
   output logic                 done,
   output logic [2*WIDTH-1:0]   product,
   output logic [WIDTH-1:0]     add_x,
   output logic [WIDTH-1:0]     add_y,
   output logic                 add_cin,
   input  logic [WIDTH-1:0]     add_s,
   input  logic                 add_cout,
   input  logic                 add_ov
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_DONE = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

   state_t             state;
   logic [WIDTH-1:0]   acc;     // accumulator A (upper product half)
   logic [WIDTH-1:0]   mq;      // multiplier Q (lower product half)
   logic [WIDTH-1:0]   mcand;   // multiplicand M
   logic [CNT_W-1:0]   cnt;
   logic [WIDTH-1:0]   acc_next;

`ifdef SIGNED_MULT_EN
   logic               q_m1;    // Booth history bit Q[-1]
   logic               unused_cout;
   assign unused_cout = add_cout;
`else
   logic               unused_ov;
   assign unused_ov = add_ov;
`endif

   assign product = {acc, mq};

   // Adder operand selection: purely from registers, valid in every state
   always_comb begin
      add_x   = acc;
      add_y   = '0;
      add_cin = 1'b0;
`ifdef SIGNED_MULT_EN
      case ({mq[0], q_m1})
         2'b01:   begin add_y = mcand; add_cin = 1'b0; end
         2'b10:   begin add_y = mcand; add_cin = 1'b1; end
         default: begin add_y = '0;    add_cin = 1'b0; end
      endcase
`else
      add_y   = mq[0] ? mcand : '0;
`endif
   end

   // Shifted accumulator: carry-in at the top (unsigned) or true sign (Booth)
   always_comb begin
`ifdef SIGNED_MULT_EN
      acc_next = {add_s[WIDTH-1] ^ add_ov, add_s[WIDTH-1:1]};
`else
      acc_next = {add_cout, add_s[WIDTH-1:1]};
`endif
   end

   // Control FSM and datapath registers with registered busy/done
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= S_IDLE;
         acc   <= '0;
         mq    <= '0;
         mcand <= '0;
         cnt   <= '0;
         busy  <= 1'b0;
         done  <= 1'b0;
`ifdef SIGNED_MULT_EN
         q_m1  <= 1'b0;
`endif
      end else begin
         case (state)
            S_IDLE, S_DONE: begin
               done <= 1'b0;
               if (start) begin
                  mcand <= a_in;
                  mq    <= b_in;
                  acc   <= '0;
                  cnt   <= '0;
`ifdef SIGNED_MULT_EN
                  q_m1  <= 1'b0;
`endif
                  state <= S_CALC;
                  busy  <= 1'b1;
               end else begin
                  state <= S_IDLE;
                  busy  <= 1'b0;
               end
            end
            S_CALC: begin
               acc <= acc_next;
               mq  <= {add_s[0], mq[WIDTH-1:1]};
`ifdef SIGNED_MULT_EN
               q_m1 <= mq[0];
`endif
               cnt <= cnt + 1'b1;
               if (cnt == LAST_ITER) begin
                  state <= S_DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end
            end
            default: begin
               state <= S_IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_seq_mult_16bit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seq_mult_16bit
//  Description : Self-checking bench for seq_mult_16bit with an external
//                ripple-adder model and a transaction-level reference model.
//                Honours SIGNED_MULT_EN like the design.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_seq_mult_16bit;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic [15:0] a_in = '0;
   logic [15:0] b_in = '0;
   logic        busy, done;
   logic [31:0] product;
   logic [15:0] add_x, add_y, add_s;
   logic        add_cin, add_cout, add_ov;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   seq_mult_16bit #(.WIDTH(16), .CNT_W(5)) dut (
      .clk(clk), .reset(reset), .start(start), .a_in(a_in), .b_in(b_in),
      .busy(busy), .done(done), .product(product),
      .add_x(add_x), .add_y(add_y), .add_cin(add_cin),
      .add_s(add_s), .add_cout(add_cout), .add_ov(add_ov)
   );

   // External two's-complement adder: cin=1 means x - y
   logic [15:0] yy;
   always_comb begin
      yy = add_cin ? ~add_y : add_y;
      {add_cout, add_s} = {1'b0, add_x} + {1'b0, yy} + {16'b0, add_cin};
      add_ov = (add_x[15] == yy[15]) && (add_s[15] != add_x[15]);
   end

   // Reference product computed by plain arithmetic
   function automatic logic [31:0] ref_mult(input logic [15:0] a, input logic [15:0] b);
`ifdef SIGNED_MULT_EN
      int sa, sb, p;
      sa = int'($signed(a));
      sb = int'($signed(b));
      p  = sa * sb;
      return p;
`else
      logic [31:0] p;
      p = {16'b0, a} * {16'b0, b};
      return p;
`endif
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Transaction-level model: 16 busy cycles after acceptance, then one done cycle
   int          m_left = 0;
   bit          m_done = 1'b0;
   logic [31:0] m_prod = '0;
   logic [31:0] m_pend = '0;
   bit          cmp_en = 1'b0;

   always @(posedge clk) begin
      if (reset) begin
         m_left = 0; m_done = 0; m_prod = '0;
      end else if (m_left > 0) begin
         m_left = m_left - 1;
         if (m_left == 0) begin
            m_done = 1;
            m_prod = m_pend;
         end
      end else begin
         m_done = 0;
         if (start) begin
            m_left = 16;
            m_pend = ref_mult(a_in, b_in);
         end
      end
   end

   // Compare outputs against the model every cycle, away from the clock edge
   always @(negedge clk) begin
      if (cmp_en) begin
         chk("busy", {31'b0, busy}, {31'b0, m_left > 0});
         chk("done", {31'b0, done}, {31'b0, m_done});
         if (m_left == 0) chk("product_idle", product, m_prod);
      end
   end

   task automatic launch(input logic [15:0] a, input logic [15:0] b);
      @(negedge clk); #1;
      a_in = a; b_in = b; start = 1'b1;
      @(negedge clk); #1;
      start = 1'b0;
   endtask

   // Called one cycle after the accept edge; edges counts from the accept edge
   task automatic wait_done(input logic [31:0] exp, input int glitch, input string name);
      int edges;
      edges = 1;
      while (edges < 40 && !done) begin
         start = (edges == glitch);
         if (start) begin a_in = $urandom; b_in = $urandom; end
         @(negedge clk); #1;
         edges++;
      end
      start = 1'b0;
      chk({name, "_latency"}, edges, 17);
      chk({name, "_product"}, product, exp);
   endtask

   initial begin
      logic [15:0] ra, rb;
      int nb;
      // Pin the reference model itself
      chk("ref_ffff_ffff_lit", ref_mult(16'hFFFF, 16'hFFFF),
`ifdef SIGNED_MULT_EN
          32'h00000001);
`else
          32'hFFFE0001);
`endif
      chk("ref_3_5_lit", ref_mult(16'd3, 16'd5), 32'h0000000F);

      // Reset for two cycles
      @(negedge clk); #1; reset = 1'b1;
      repeat (2) @(negedge clk);
      chk("rst_busy", {31'b0, busy}, 32'h0);
      chk("rst_done", {31'b0, done}, 32'h0);
      chk("rst_product", product, 32'h0);
      chk("rst_add_x", {16'b0, add_x}, 32'h0);
      chk("rst_add_y", {16'b0, add_y}, 32'h0);
      chk("rst_add_cin", {31'b0, add_cin}, 32'h0);
      #1; reset = 1'b0;
      cmp_en = 1'b1;

`ifdef SIGNED_MULT_EN
      launch(16'hFFFF, 16'h0002); wait_done(32'hFFFFFFFE, 0, "s_m1x2");
      launch(16'h8000, 16'h8000); wait_done(32'h40000000, 0, "s_8000sq");
      launch(16'h8000, 16'h0001); wait_done(32'hFFFF8000, 0, "s_8000x1");
      launch(16'd3, 16'd5);       wait_done(32'h0000000F, 0, "s_3x5");
`else
      launch(16'hFFFF, 16'hFFFF); wait_done(32'hFFFE0001, 0, "u_ffff_sq");
      launch(16'hFFFF, 16'h0002); wait_done(32'h0001FFFE, 0, "u_ffffx2");
      launch(16'h8000, 16'h8000); wait_done(32'h40000000, 0, "u_8000sq");
      launch(16'd3, 16'd5);       wait_done(32'h0000000F, 0, "u_3x5");
`endif
      launch(16'h1234, 16'h0000); wait_done(32'h00000000, 0, "x_zero");

      // start pulsed during CALC cycle 5 must be ignored
      launch(16'h00FF, 16'h0101); wait_done(ref_mult(16'h00FF, 16'h0101), 5, "glitch");

      // start held on the done cycle: second op accepted without idle bubble
      a_in = 16'h0007; b_in = 16'h0009; start = 1'b1;
      @(negedge clk); #1; start = 1'b0;
      chk("b2b_busy", {31'b0, busy}, 32'h1);
      wait_done(32'h0000003F, 0, "b2b");

      // reset in CALC cycle 8 aborts the operation
      launch(16'h00FF, 16'h0101);
      repeat (7) @(negedge clk);
      #1; reset = 1'b1;
      @(negedge clk);
      chk("abort_busy", {31'b0, busy}, 32'h0);
      chk("abort_product", product, 32'h0);
      #1; reset = 1'b0;
      nb = 0;
      repeat (20) begin
         @(negedge clk);
         if (done) nb++;
      end
      chk("abort_no_done", nb, 0);

      // Randomized operations, some back-to-back
      for (int i = 0; i < 30; i++) begin
         ra = $urandom; rb = $urandom;
         if (i % 7 == 3) begin
            ra = 16'h8000 | ra;
            rb = 16'h8000;
         end
         launch(ra, rb);
         wait_done(ref_mult(ra, rb), (i % 5 == 0) ? int'($urandom_range(2, 15)) : 0, "rand");
         if (i % 4 == 1) begin
            ra = $urandom; rb = $urandom;
            a_in = ra; b_in = rb; start = 1'b1;
            @(negedge clk); #1; start = 1'b0;
            wait_done(ref_mult(ra, rb), 0, "rand_b2b");
         end
         repeat ($urandom_range(0, 3)) @(negedge clk);
      end

      repeat (3) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
